rr_packet_sender: RTL and testbench
===================================

RR_PACKET_SENDER -- requirements
Module: rr_packet_sender

Interface
REQ-001 SHALL have parameter UWIDTH, default 8, byte width of every packet word.
REQ-002 SHALL have parameter PTR_IN_SZ, default 4, width of the in-packet word address.
REQ-003 SHALL have parameter N_CH, default 4, number of source FIFO channels (2..8).
REQ-004 SHALL have parameter CH_SZ, default 2, width of the channel index (>= clog2(N_CH)).
REQ-005 SHALL have parameter CRC_CHECK, default 1: 1 = check CRC, 0 = crc_err tied low.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port rempty  input  N_CH  per-channel FIFO empty, bit c = channel c.
REQ-009 SHALL have port rdata  input  N_CH*UWIDTH  per-channel read word; channel c occupies bits [c*UWIDTH +: UWIDTH], valid in the same cycle as raddr_in (combinational FIFO read).
REQ-010 SHALL have port rinc  output  N_CH  one-hot, one-cycle pop of the granted channel's head packet.
REQ-011 SHALL have port raddr_in  output  PTR_IN_SZ  word index within the head packet, broadcast to all channels.
REQ-012 SHALL have port out_ready  input  1  downstream accepts packet_out this cycle.
REQ-013 SHALL have port packet_valid  output  1  packet_out holds a valid word.
REQ-014 SHALL have port packet_out  output  UWIDTH  outgoing word.
REQ-015 SHALL have ports packet_sop / packet_eop  output  1 each  first word (source_id) / last word (crc) flags, qualified by packet_valid.
REQ-016 SHALL have port packet_ch  output  CH_SZ  channel index of the packet in flight.
REQ-017 SHALL have ports crc_err / size_err  output  1 each  one-cycle pulses concurrent with the accepted eop word.

Function
REQ-018 Packet format SHALL be: word0 source_id, word1 dest_id, word2 size S, words 3..S+2 data, word S+3 crc; total length S+4 words.
REQ-019 MAX_SIZE SHALL be 2^PTR_IN_SZ-4 (12 at default); S > MAX_SIZE SHALL be treated as MAX_SIZE and SHALL raise size_err on the eop word.
REQ-020 FSM SHALL have states IDLE, SEND, POP.
REQ-021 IDLE: when any rempty bit is 0, grant the first non-empty channel after last_grant in ascending wrap-around order, latch it into packet_ch, set raddr_in = 0, go to SEND at the next edge; otherwise stay in IDLE.
REQ-022 SEND: packet_valid = 1, packet_out = granted channel's rdata; on out_ready = 1 raddr_in increments; on out_ready = 0 raddr_in, packet_out and all flags SHALL hold.
REQ-023 The word at raddr_in = 2 SHALL be latched as S when it is accepted.
REQ-024 When the word at raddr_in = S+3 is accepted, the FSM SHALL go to POP; packet_eop = 1 on that word only; packet_sop = 1 only on raddr_in = 0.
REQ-025 POP: rinc[grant] = 1 for exactly one cycle, last_grant <= grant, packet_valid = 0, next state IDLE.
REQ-026 Minimum gap between the eop word of one packet and the sop word of the next SHALL be 2 cycles (POP, IDLE).
REQ-027 CRC SHALL be the XOR of words 0..S+2; crc_err = CRC_CHECK AND (computed != word S+3); the packet SHALL be forwarded and popped regardless.
REQ-028 rempty changes during SEND SHALL NOT affect the packet in flight; other channels wait for IDLE.
REQ-029 rinc SHALL never assert for a channel whose rempty bit was 1 in the granting IDLE cycle.

Reset
REQ-030 On rst = 1 at a clock edge: state = IDLE, raddr_in = 0, rinc = 0, packet_valid = 0, packet_out = 0, sop/eop = 0, crc_err = size_err = 0, packet_ch = 0, last_grant = N_CH-1 (channel 0 wins first).
REQ-031 Reset mid-packet SHALL abort without popping; the interrupted packet is resent from word 0 after reset.

Verification
REQ-032 Single packet ch0 {10,160,3,0,1,2,170}, out_ready = 1 -> 7 consecutive valid words, sop on 10, eop on 170, crc_err = 0, rinc = 0001 one cycle after eop.
REQ-033 Same packet with crc 15 -> identical output, crc_err pulse on the eop word, packet still popped.
REQ-034 Channels 0, 2, 3 non-empty from reset, one packet each -> service order 0, 2, 3, packet_ch matching, 2-cycle gaps.
REQ-035 out_ready held 0 for 3 cycles while word2 is presented -> packet_out = size held for those 3 cycles, raddr_in frozen, no words lost or duplicated.
REQ-036 Packet with S = 15 (PTR_IN_SZ = 4) -> 16 words sent (S treated as 12), size_err on eop.
REQ-037 rst asserted while word4 is presented -> outputs reset next edge, no rinc; after release the same packet is resent from source_id.

Source files
------------

// File: rtl/rr_packet_sender.sv
// Round-robin packet sender: picks the next non-empty FIFO channel, streams its head
// packet word by word under out_ready backpressure, checks size/CRC, then pops it.
module rr_packet_sender #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int N_CH      = 4,
  parameter int CH_SZ     = 2,
  parameter int CRC_CHECK = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          rempty,
  input  logic [N_CH*UWIDTH-1:0]   rdata,
  output logic [N_CH-1:0]          rinc,
  output logic [PTR_IN_SZ-1:0]     raddr_in,
  input  logic                     out_ready,
  output logic                     packet_valid,
  output logic [UWIDTH-1:0]        packet_out,
  output logic                     packet_sop,
  output logic                     packet_eop,
  output logic [CH_SZ-1:0]         packet_ch,
  output logic                     crc_err,
  output logic                     size_err
);
  localparam int MAX_SIZE = 2**PTR_IN_SZ - 4;

  typedef enum logic [1:0] {IDLE, SEND, POP} state_t;

  state_t                state_q, state_d;
  logic [PTR_IN_SZ-1:0]  raddr_q, raddr_d;
  logic [PTR_IN_SZ-1:0]  eop_addr_q, eop_addr_d;
  logic                  size_vld_q, size_vld_d;
  logic                  size_ovf_q, size_ovf_d;
  logic [UWIDTH-1:0]     crc_q, crc_d;
  logic [CH_SZ-1:0]      grant_q, grant_d;
  logic [CH_SZ-1:0]      last_q, last_d;

  logic [N_CH-1:0]       rot;
  logic                  found;
  logic [CH_SZ-1:0]      pick;
  int                    off, pick_i, size_eff;
  logic [UWIDTH-1:0]     cur_word;
  logic                  at_eop;

  assign cur_word  = rdata[int'(grant_q)*UWIDTH +: UWIDTH];
  assign raddr_in  = raddr_q;
  assign packet_ch = grant_q;

  // Rotate the request vector so bit 0 is the channel just after last_grant.
  always_comb begin
    rot    = N_CH'(({~rempty, ~rempty} >> last_q) >> 1);
    found  = |rot;
    off    = 0;
    for (int i = N_CH-1; i >= 0; i--)
      if (rot[i]) off = i;
    pick_i = int'(last_q) + 1 + off;
    if (pick_i >= N_CH) pick_i = pick_i - N_CH;
    pick   = CH_SZ'(pick_i);
  end

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    eop_addr_d   = eop_addr_q;
    size_vld_d   = size_vld_q;
    size_ovf_d   = size_ovf_q;
    crc_d        = crc_q;
    grant_d      = grant_q;
    last_d       = last_q;
    rinc         = '0;
    packet_valid = 1'b0;
    packet_out   = '0;
    packet_sop   = 1'b0;
    packet_eop   = 1'b0;
    crc_err      = 1'b0;
    size_err     = 1'b0;
    at_eop       = 1'b0;
    size_eff     = 0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          raddr_d    = '0;
          crc_d      = '0;
          size_vld_d = 1'b0;
          size_ovf_d = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        at_eop       = size_vld_q && (raddr_q == eop_addr_q);
        packet_valid = 1'b1;
        packet_out   = cur_word;
        packet_sop   = (raddr_q == '0);
        packet_eop   = at_eop;
        if (out_ready) begin
          if (at_eop) begin
            crc_err  = (CRC_CHECK != 0) && (crc_q != cur_word);
            size_err = size_ovf_q;
            raddr_d  = '0;
            state_d  = POP;
          end else begin
            crc_d   = crc_q ^ cur_word;
            raddr_d = raddr_q + 1'b1;
            // Oversized packets are truncated: the crc is taken at word MAX_SIZE+3.
            if (raddr_q == PTR_IN_SZ'(2)) begin
              size_ovf_d = (cur_word > UWIDTH'(MAX_SIZE));
              size_eff   = size_ovf_d ? MAX_SIZE : int'(cur_word);
              eop_addr_d = PTR_IN_SZ'(size_eff + 3);
              size_vld_d = 1'b1;
            end
          end
        end
      end
      POP: begin
        rinc    = N_CH'(1) << grant_q;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      eop_addr_q <= '0;
      size_vld_q <= 1'b0;
      size_ovf_q <= 1'b0;
      crc_q      <= '0;
      grant_q    <= '0;
      last_q     <= CH_SZ'(N_CH-1);
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      eop_addr_q <= eop_addr_d;
      size_vld_q <= size_vld_d;
      size_ovf_q <= size_ovf_d;
      crc_q      <= crc_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
  end
endmodule

// File: tb/tb_rr_packet_sender.sv
// Bench for rr_packet_sender: FIFO models feed the DUT, a packet-level model predicts every
// output word, plus literal expectations for the directed scenarios.
module tb_rr_packet_sender;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  rinc;
  logic [3:0]  raddr_in;
  logic        out_ready = 1'b1;
  logic        packet_valid;
  logic [7:0]  packet_out;
  logic        packet_sop, packet_eop;
  logic [1:0]  packet_ch;
  logic        crc_err, size_err;

  rr_packet_sender dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .raddr_in(raddr_in), .out_ready(out_ready), .packet_valid(packet_valid),
    .packet_out(packet_out), .packet_sop(packet_sop), .packet_eop(packet_eop),
    .packet_ch(packet_ch), .crc_err(crc_err), .size_err(size_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Source FIFOs: 4 channels x 4 packets x 16 words, popped by rinc.
  logic [7:0] mem [4][4][16];
  int head [4] = '{0, 0, 0, 0};
  int tail [4] = '{0, 0, 0, 0};

  always @(posedge clk)
    for (int c = 0; c < 4; c++)
      if (rinc[c]) head[c] <= head[c] + 1;

  always_comb begin
    rdata  = '0;
    rempty = '1;
    for (int c = 0; c < 4; c++) begin
      rempty[c]       = (head[c] == tail[c]);
      rdata[c*8 +: 8] = mem[c][head[c] % 4][raddr_in];
    end
  end

  task automatic push_pkt(input int c, input int src, input int dst, input int s,
                          input int d0, input int crc_v);
    int n, slot;
    logic [7:0] x;
    logic [7:0] w [16];
    n = (s > 12) ? 12 : s;
    w[0] = 8'(src); w[1] = 8'(dst); w[2] = 8'(s);
    x = w[0] ^ w[1] ^ w[2];
    for (int i = 0; i < n; i++) begin
      w[3+i] = 8'(d0 + i);
      x = x ^ w[3+i];
    end
    w[n+3] = (crc_v < 0) ? x : 8'(crc_v);
    slot = tail[c] % 4;
    for (int i = 0; i <= n + 3; i++) mem[c][slot][i] = w[i];
    tail[c]++;
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < 4; c++) if (head[c] != tail[c]) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level model state and per-scenario logs.
  bit started = 1'b0;
  bit rst_at_edge = 1'b1;
  bit in_pkt = 1'b0, pop_pend = 1'b0, e_crc, e_size;
  int idx, len, exp_ch, pop_ch, m_last = 3, cyc = 0, stall_cnt = 0, crc_cnt = 0, size_cnt = 0;
  int ew [16];
  int word_log[$], sop_ch_log[$], sop_cyc[$], eop_cyc[$], pop_cyc[$];

  task automatic clear_logs();
    word_log.delete(); sop_ch_log.delete(); sop_cyc.delete(); eop_cyc.delete(); pop_cyc.delete();
    stall_cnt = 0; crc_cnt = 0; size_cnt = 0;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (head[c] != tail[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    rst_at_edge <= rst;
    started     <= 1'b1;
  end

  always @(negedge clk) if (started) begin
    cyc++;
    if (rst_at_edge) begin
      chk("rst_valid", packet_valid, 0);
      chk("rst_out", packet_out, 0);
      chk("rst_sop", packet_sop, 0);
      chk("rst_eop", packet_eop, 0);
      chk("rst_rinc", rinc, 0);
      chk("rst_raddr", raddr_in, 0);
      chk("rst_ch", packet_ch, 0);
      chk("rst_crc_err", crc_err, 0);
      chk("rst_size_err", size_err, 0);
      in_pkt = 1'b0; pop_pend = 1'b0; m_last = 3;
    end else begin
      if (pop_pend) begin
        chk("pop_rinc", rinc, 32'(1) << pop_ch);
        chk("pop_valid", packet_valid, 0);
        pop_pend = 1'b0;
        m_last = pop_ch;
        pop_cyc.push_back(cyc);
      end else begin
        chk("rinc_idle", rinc, 0);
      end
      if (packet_valid) begin
        if (!in_pkt) begin
          int slot, s_raw, s_eff;
          logic [7:0] x;
          exp_ch = rr_pick();
          chk("grant_nonempty", exp_ch >= 0, 1);
          if (exp_ch < 0) exp_ch = 0;
          slot  = head[exp_ch] % 4;
          s_raw = int'(mem[exp_ch][slot][2]);
          s_eff = (s_raw > 12) ? 12 : s_raw;
          len   = s_eff + 4;
          x = 8'h00;
          for (int i = 0; i < len; i++) begin
            ew[i] = int'(mem[exp_ch][slot][i]);
            if (i < len - 1) x = x ^ mem[exp_ch][slot][i];
          end
          e_crc  = (x != mem[exp_ch][slot][len-1]);
          e_size = (s_raw > 12);
          in_pkt = 1'b1;
          idx    = 0;
          sop_ch_log.push_back(exp_ch);
          sop_cyc.push_back(cyc);
        end
        chk("pkt_ch", packet_ch, exp_ch);
        chk("raddr", raddr_in, idx);
        chk("word", packet_out, ew[idx]);
        chk("sop", packet_sop, idx == 0);
        chk("eop", packet_eop, idx == len - 1);
        if (raddr_in == 4'd2) stall_cnt++;
        if (out_ready) begin
          chk("crc_err", crc_err, (idx == len - 1) && e_crc);
          chk("size_err", size_err, (idx == len - 1) && e_size);
          if (crc_err) crc_cnt++;
          if (size_err) size_cnt++;
          word_log.push_back(int'(packet_out));
          if (idx == len - 1) begin
            in_pkt = 1'b0; pop_pend = 1'b1; pop_ch = exp_ch;
            eop_cyc.push_back(cyc);
          end
          idx++;
        end else begin
          chk("crc_err_stall", crc_err, 0);
          chk("size_err_stall", size_err, 0);
        end
      end else begin
        chk("valid_drop", in_pkt, 0);
        chk("idle_sop", packet_sop, 0);
        chk("idle_eop", packet_eop, 0);
        chk("idle_crc_err", crc_err, 0);
        chk("idle_size_err", size_err, 0);
      end
    end
  end

  task automatic wait_done(input bit rnd);
    int k;
    k = 0;
    while (k < 600 && !(all_empty() && !packet_valid && !pop_pend)) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    out_ready = 1'b1;
    chk("done_in_time", k < 600, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input int a);
    int k;
    k = 0;
    while (k < 100 && !(packet_valid && raddr_in == 4'(a))) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_word", k < 100, 1);
  endtask

  int exp1 [7] = '{10, 160, 3, 0, 1, 2, 170};
  int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    // Reset state, then the basic single-packet case.
    push_pkt(0, 10, 160, 3, 0, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_done(0);
    chk("t1_len", word_log.size(), 7);
    foreach (exp1[i]) chk("t1_word", word_log[i], exp1[i]);
    chk("t1_crc_cnt", crc_cnt, 0);
    chk("t1_pop_lat", pop_cyc[0] - eop_cyc[0], 1);

    // Bad CRC: same stream, error pulse, still popped.
    clear_logs();
    push_pkt(0, 10, 160, 3, 0, 15);
    wait_done(0);
    chk("t2_len", word_log.size(), 7);
    chk("t2_last", word_log[6], 15);
    chk("t2_crc_cnt", crc_cnt, 1);
    chk("t2_pops", pop_cyc.size(), 1);
    chk("t2_empty", head[0] == tail[0], 1);

    // Three channels loaded from reset: order 0,2,3 with minimum gaps.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 clear_logs();
    push_pkt(0, 1, 2, 1, 3, -1);
    push_pkt(2, 4, 5, 0, 0, -1);
    push_pkt(3, 6, 7, 2, 8, -1);
    rst = 1'b0;
    wait_done(0);
    chk("t3_n", sop_ch_log.size(), 3);
    chk("t3_ch0", sop_ch_log[0], 0);
    chk("t3_ch1", sop_ch_log[1], 2);
    chk("t3_ch2", sop_ch_log[2], 3);
    chk("t3_gap0", sop_cyc[1] - eop_cyc[0], 3);
    chk("t3_gap1", sop_cyc[2] - eop_cyc[1], 3);

    // Backpressure on the size word for three cycles.
    clear_logs();
    push_pkt(1, 8'h21, 7, 2, 5, -1);
    wait_word(2);
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_done(0);
    chk("t4_stall_cycles", stall_cnt, 4);
    chk("t4_len", word_log.size(), 6);
    chk("t4_size", word_log[2], 2);
    chk("t4_crc", word_log[5], 8'h27);

    // Oversized packet: truncated to 16 words with size_err.
    clear_logs();
    push_pkt(2, 1, 2, 15, 8'h40, -1);
    wait_done(0);
    chk("t5_len", word_log.size(), 16);
    chk("t5_size_cnt", size_cnt, 1);
    chk("t5_crc_cnt", crc_cnt, 0);

    // Reset while word 4 is presented: abort, no pop, resend from word 0.
    clear_logs();
    push_pkt(3, 8'h33, 1, 5, 9, -1);
    wait_word(4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done(0);
    chk("t6_len", word_log.size(), 14);
    chk("t6_resend_src", word_log[5], 8'h33);
    chk("t6_sops", sop_ch_log.size(), 2);
    chk("t6_pops", pop_cyc.size(), 1);

    // All channels busy under random backpressure: strict rotation.
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        push_pkt(c, 16*c + r, 3, (c + r * 5) % 14, 20 * c, (c == 1 && r == 1) ? 0 : -1);
    wait_done(1);
    chk("t7_n", sop_ch_log.size(), 8);
    foreach (exp_rr[i]) chk("t7_rr", sop_ch_log[i], exp_rr[i]);
    chk("t7_pops", pop_cyc.size(), 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
